ring_net: RTL
=============

# ring_net

Parametrised unidirectional ring interconnect for the cache-network simulator, the successor of the fixed three-node ring. It carries `pkt_t` packets from per-node injection ports to per-node ejection ports with valid/ready handshakes on both sides, so no packet is ever dropped or overwritten. Each node has a configurable-depth transit buffer with bubble flow control, which prevents ring deadlock. A starvation counter guarantees that local injection eventually gets a slot under sustained through-traffic. The block sits between the core-side software model and the cache agents.

## Interface
- `NUM_NODES`, default 4: number of ring stops, ≥2.
- `DEPTH`, default 8: transit FIFO entries per node, ≥2, not restricted to powers of 2.
- `STARVE_LIMIT`, default 4: number of consecutive blocked injection cycles before injection is forced.
- `clk`, input, 1: the only clock; all state updates on posedge.
- `rst_l`, input, 1: asynchronous, active-low reset.
- `inj_valid`, input, `[NUM_NODES]`: node i offers a packet for injection.
- `inj_pkt`, input, `pkt_t [NUM_NODES]`: the injected packet (src, dest, data).
- `inj_ready`, output, `[NUM_NODES]`: the injection is accepted on the edge where valid && ready.
- `ej_valid`, output, `[NUM_NODES]`: a packet addressed to node i is presented.
- `ej_pkt`, output, `pkt_t [NUM_NODES]`: the ejected packet; it is 0 when `ej_valid` is low.
- `ej_ready`, input, `[NUM_NODES]`: the consumer takes the packet on the edge where valid && ready.
- `drop_err`, output, `[NUM_NODES]`: one-cycle pulse when an accepted injection has `dest >= NUM_NODES`.

## Operation
- **Ring order.** Upstream of node i is node (i-1) mod N. The head of node i's FIFO is offered combinationally to node (i+1) mod N.
- **Arriving packet.** At node j, an arriving head with `dest == j` drives `ej_valid`. It pops upstream only when `ej_ready` is high.
- **Forwarding.** An arriving head with `dest != j` is written into FIFO j when FIFO j has space. Space includes the slot freed by FIFO j's own pop in the same cycle. The upstream pop happens only when that write happens.
- **Injection with a remote destination** (`dest != i`): it is written into FIFO i.
  - **Bubble rule:** injection requires count_after_pop ≤ DEPTH-2, so one slot is always left for through-traffic.
  - **Arbitration:** through-traffic wins the FIFO write port by default.
  - **Starvation:** `starve_cnt[i]` increments on each cycle where `inj_valid` is high but injection loses arbitration only. When it equals `STARVE_LIMIT`, injection wins that cycle: the upstream forward stalls and the counter clears. The counter also clears on any accepted injection or when `inj_valid` is low.
- **Self-addressed injection** (`dest == i`): it competes for the ejection port and bypasses the FIFO. An arriving ring packet has priority. `inj_ready` = `ej_ready` && no ring packet is ejecting at i.
- **Invalid destination** (`dest >= NUM_NODES`): `inj_ready` = 1. The packet is discarded, and `drop_err` is registered and pulses in the following cycle.
- **FIFO rules.**
  - Writing to a full FIFO is blocked by the ready logic.
  - Read and write in the same cycle leave the count unchanged, including when the FIFO is full.
  - Pointers wrap at DEPTH, not at a power of 2.

## Timing
- **Reset values:**
  - All FIFOs empty; `starve_cnt` = 0.
  - `ej_valid` = 0, `ej_pkt` = 0, `drop_err` = 0.
  - `inj_ready` = 1 for every node, because it is combinational from the empty state.
  - Reset asserted mid-operation discards all in-flight packets immediately.
- **Latency:**
  - A remote injection accepted at edge t reaches node src+k (mod N) and asserts `ej_valid` there during cycle t+k-1. That is k-1 cycles after the edge, one edge per intermediate hop, with no contention.
  - Self-addressed: `ej_valid` in the same cycle as `inj_valid`, combinational.
- `ej_valid` and `ej_pkt` are held stable until accepted.
- **Throughput:** one packet per node per cycle on each of forward, eject and inject.

## Structure
- `NetworkPkg` holds `pkt_t` {src[ID_SIZE], dest[ID_SIZE], data[DATA_WIDTH]}, plus `ID_SIZE` and `DATA_WIDTH`.
- Sub-module `ring_fifo #(WIDTH, DEPTH)`:
  - count width `$clog2(DEPTH+1)`, pointer width `$clog2(DEPTH)`;
  - combinational head read;
  - registered count/full/empty.
- All per-node arbitration goes in a generate loop inside `ring_net`.

## Test plan
- **Single hop sweep.** N=4. Inject at node 0 with dest=2, data=0x1234. Expect `ej_valid[2]` one cycle after acceptance with the same packet, and nothing at nodes 1 or 3.
- **Self-addressed bypass.** Node 1 injects with dest=1 while `ej_ready[1]`=1 and there is no ring traffic. Expect `ej_valid[1]` in the same cycle. Hold `ej_ready[1]`=0: `inj_ready[1]`=0 and the packet is held.
- **Backpressure.** Hold `ej_ready[3]`=0. Node 0 injects 12 packets for node 3 with DEPTH=4. Expect:
  - FIFOs fill;
  - `inj_ready[0]` drops when count ≥ DEPTH-1;
  - release delivers all 12 in order, with none lost.
- **Starvation.** Saturate through-traffic into node 2 from nodes 0 and 1, and hold `inj_valid[2]`. Expect injection at node 2 accepted within `STARVE_LIMIT`+1 cycles, repeating periodically.
- **All-to-all saturation.** Random dest, 10k cycles, `ej_ready` random at 50%. Expect:
  - no deadlock;
  - per-src-dest ordering preserved;
  - injected count equals ejected count plus `drop_err` count.
- **Reset mid-flight.** Pull `rst_l` low asynchronously with FIFOs half full. Expect `ej_valid` = 0 immediately and `inj_ready` = 1 after release.

Source files
------------

// File: rtl/ring_net_pkg.sv
// Shared packet format for the ring interconnect.
// Node ids and payload width are fixed here for every ring instance.
package NetworkPkg;

  localparam int ID_SIZE    = 4;
  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic [ID_SIZE-1:0]    src;
    logic [ID_SIZE-1:0]    dest;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

endpackage

// File: rtl/ring_fifo.sv
// Per-node transit FIFO: combinational head, registered count/full/empty.
// Pointers wrap at DEPTH so any depth >= 2 is legal.
module ring_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count_nxt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count;
    unique case ({wr, rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) wptr <= bump(wptr);
      if (rd) rptr <= bump(rptr);
      count <= count_nxt;
      full  <= count_nxt == CW'(DEPTH);
      empty <= count_nxt == '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/ring_net.sv
// Unidirectional ring with bubble flow control, local bypass and
// starvation-forced injection; node i feeds node (i+1) mod N.
module ring_net
  import NetworkPkg::*;
#(
  parameter int NUM_NODES    = 4,
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [NUM_NODES-1:0] inj_valid,
  input  pkt_t [NUM_NODES-1:0] inj_pkt,
  output logic [NUM_NODES-1:0] inj_ready,
  output logic [NUM_NODES-1:0] ej_valid,
  output pkt_t [NUM_NODES-1:0] ej_pkt,
  input  logic [NUM_NODES-1:0] ej_ready,
  output logic [NUM_NODES-1:0] drop_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [ID_SIZE:0] NODES = (ID_SIZE+1)'(NUM_NODES);

  for (genvar i = 0; i < NUM_NODES; i++) begin : node
    localparam int UP = (i + NUM_NODES - 1) % NUM_NODES;
    localparam int DN = (i + 1) % NUM_NODES;

    pkt_t          head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          pop_up;
    logic          pop_seen;
    pkt_t          arr_pkt;
    logic          arr_valid;
    logic          arr_local;
    logic          arr_fwd;
    pkt_t          ip;
    logic          inj_bad;
    logic          inj_self;
    logic          inj_remote;
    logic          space;
    logic          inj_room;
    logic          force_inj;
    logic          wr_fwd;
    logic          wr_inj;
    logic          wr;
    pkt_t          wdata;
    logic          rdy;
    logic          drop_q;
    logic [SW-1:0] starve_cnt;

    assign arr_valid = !node[UP].empty;
    assign arr_pkt   = node[UP].head;
    assign pop       = node[DN].pop_up;
    assign arr_local = arr_valid && arr_pkt.dest == ID_SIZE'(i);
    assign arr_fwd   = arr_valid && !arr_local;

    assign ip         = inj_pkt[i];
    assign inj_bad    = {1'b0, ip.dest} >= NODES;
    assign inj_self   = ip.dest == ID_SIZE'(i);
    assign inj_remote = !inj_bad && !inj_self;

    // Node 0 ignores its own pop: this cuts the ring-wide space/pop loop.
    if (i == 0) begin : cut
      assign pop_seen = 1'b0;
    end else begin : thru
      assign pop_seen = pop;
    end

    assign space     = !full || pop_seen;
    assign inj_room  = (count - CW'(pop_seen)) <= CW'(DEPTH-2);
    assign force_inj = inj_valid[i] && inj_remote && inj_room &&
                       starve_cnt == SW'(STARVE_LIMIT);
    assign wr_fwd    = arr_fwd && space && !force_inj;
    assign wr_inj    = inj_valid[i] && inj_remote && inj_room && !wr_fwd;
    assign wr        = wr_fwd || wr_inj;
    assign wdata     = wr_fwd ? arr_pkt : ip;
    assign pop_up    = wr_fwd || (arr_local && ej_ready[i]);

    always_comb begin
      rdy = 1'b0;
      unique case (1'b1)
        inj_bad:  rdy = 1'b1;
        inj_self: rdy = ej_ready[i] && !arr_local;
        default:  rdy = inj_room && !wr_fwd;
      endcase
    end

    assign inj_ready[i] = rdy;
    assign ej_valid[i]  = arr_local || (inj_valid[i] && inj_self);
    assign ej_pkt[i]    = arr_local ? arr_pkt :
                          (inj_valid[i] && inj_self) ? ip : '0;
    assign drop_err[i]  = drop_q;

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        starve_cnt <= '0;
        drop_q     <= 1'b0;
      end else begin
        drop_q <= inj_valid[i] && inj_bad;
        if (!inj_valid[i] || rdy)
          starve_cnt <= '0;
        else if (inj_remote && inj_room && wr_fwd)
          starve_cnt <= starve_cnt + 1'b1;
      end
    end

    ring_fifo #(
      .WIDTH($bits(pkt_t)),
      .DEPTH(DEPTH)
    ) fifo (
      .clk  (clk),
      .rst_l(rst_l),
      .wr   (wr),
      .wdata(wdata),
      .rd   (pop),
      .head (head),
      .count(count),
      .full (full),
      .empty(empty)
    );
  end

endmodule
